// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (double-dabble, one input bit per clock) with start/busy/done handshake.
// Optional two's-complement input with sign output when BCD_SEQ_SIGNED_EN is defined.
module bcd_seq_converter #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       in_num,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  sign
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic [IN_W-1:0]   shreg_r;
  logic [BW-1:0]     dig_r;
  logic              ovf_acc_r;
  logic [CW-1:0]     cnt_r;
  logic [IN_W-1:0]   mag_s;
  logic [BW-1:0]     adj_s;
  logic [BW-1:0]     dig_shift_s;
  logic              carry_s;
  logic              accept_s;
  logic              last_s;

  // Digit correction applied before every shift
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

`ifdef BCD_SEQ_SIGNED_EN
  logic sign_acc_r;
  // Magnitude of the two's-complement input; most negative value yields 2^(IN_W-1)
  assign mag_s = in_num[IN_W-1] ? (~in_num + IN_W'(1)) : in_num;
`else
  assign mag_s = in_num;
  assign sign  = 1'b0;
`endif

  // Correct each digit, then shift {digits, shreg} left by one
  always_comb begin
    adj_s = {BW{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      adj_s[4*k +: 4] = add3(dig_r[4*k +: 4]);
    end
    dig_shift_s = {adj_s[BW-2:0], shreg_r[IN_W-1]};
    carry_s     = adj_s[BW-1];
  end

  // Next-state logic and accept/last-shift decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == {CW{1'b0}}) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, working registers and published results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shreg_r   <= {IN_W{1'b0}};
      dig_r     <= {BW{1'b0}};
      ovf_acc_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= {BW{1'b0}};
      overflow  <= 1'b0;
`ifdef BCD_SEQ_SIGNED_EN
      sign_acc_r <= 1'b0;
      sign       <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == SHIFT);
      done    <= (state_nxt_s == DONE);
      if (accept_s) begin
        shreg_r   <= mag_s;
        dig_r     <= {BW{1'b0}};
        ovf_acc_r <= 1'b0;
        cnt_r     <= CW'(IN_W - 1);
`ifdef BCD_SEQ_SIGNED_EN
        sign_acc_r <= in_num[IN_W-1];
`endif
      end else if (state_r == SHIFT) begin
        shreg_r   <= {shreg_r[IN_W-2:0], 1'b0};
        dig_r     <= dig_shift_s;
        ovf_acc_r <= ovf_acc_r | carry_s;
        cnt_r     <= cnt_r - CW'(1);
        // Results are published only with the final shift, so holding is implicit
        if (last_s) begin
          bcd      <= dig_shift_s;
          overflow <= ovf_acc_r | carry_s;
`ifdef BCD_SEQ_SIGNED_EN
          sign     <= sign_acc_r;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: default 13-bit/4-digit instance plus a 3-digit overflow instance.
// Expected values come from a decimal-arithmetic reference model (signed when BCD_SEQ_SIGNED_EN is defined).
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [12:0] in_a, in_b;
  logic        busy_a, done_a, ovf_a, sign_a;
  logic [15:0] bcd_a;
  logic        busy_b, done_b, ovf_b, sign_b;
  logic [11:0] bcd_b;

  int n_err = 0;
  int n_chk = 0;

  bcd_seq_converter #(.IN_W(13), .DIGITS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_num(in_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .sign(sign_a)
  );

  bcd_seq_converter #(.IN_W(13), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_num(in_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .sign(sign_b)
  );

  typedef struct {
    logic [12:0] in;
    logic [15:0] bcd;
    logic        ovf;
    logic        sgn;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal reference: magnitude, digit extraction by /10, overflow by range compare
  function automatic void ref_model(input logic [12:0] v, input int digits,
                                    output logic [15:0] b, output logic o, output logic s);
    int mag, lim, t;
`ifdef BCD_SEQ_SIGNED_EN
    s   = v[12];
    mag = v[12] ? (8192 - int'(v)) : int'(v);
`else
    s   = 1'b0;
    mag = int'(v);
`endif
    lim = 1;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    o = (mag >= lim);
    t = mag % lim;
    b = 16'h0000;
    for (int k = 0; k < digits; k++) begin
      b[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  // One conversion on instance sel (0=a, 1=b); returns cycles from start cycle to done and busy count
  task automatic run(input int sel, input logic [12:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    if (sel == 0) begin in_a = v; start_a = 1'b1; end
    else begin in_b = v; start_b = 1'b1; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lat = 1;
    busy_cnt = ((sel == 0) ? busy_a : busy_b) ? 1 : 0;
    while (!((sel == 0) ? done_a : done_b) && lat < 60) begin
      @(negedge clk);
      lat++;
      if ((sel == 0) ? busy_a : busy_b) busy_cnt++;
    end
  endtask

  task automatic conv_check(input string nm, input int sel, input logic [12:0] v);
    int lat, bc;
    logic [15:0] eb;
    logic eo, es;
    run(sel, v, lat, bc);
    ref_model(v, (sel == 0) ? 4 : 3, eb, eo, es);
    chk({nm, ".latency"}, 32'(lat), 32'd14);
    chk({nm, ".busy_cycles"}, 32'(bc), 32'd13);
    if (sel == 0) begin
      chk({nm, ".bcd"}, {16'h0, bcd_a}, {16'h0, eb});
      chk({nm, ".ovf"}, {31'h0, ovf_a}, {31'h0, eo});
      chk({nm, ".sign"}, {31'h0, sign_a}, {31'h0, es});
    end else begin
      chk({nm, ".bcd"}, {20'h0, bcd_b}, {20'h0, eb[11:0]});
      chk({nm, ".ovf"}, {31'h0, ovf_b}, {31'h0, eo});
      chk({nm, ".sign"}, {31'h0, sign_b}, {31'h0, es});
    end
    @(negedge clk);
    chk({nm, ".done_pulse_width"}, {31'h0, (sel == 0) ? done_a : done_b}, 32'd0);
  endtask

  initial begin
    int lat, lat2, ndone;
    logic [15:0] got, eb;
    logic eo, es;

`ifdef BCD_SEQ_SIGNED_EN
    tbl[0] = '{13'd0,        16'h0000, 1'b0, 1'b0};
    tbl[1] = '{13'd1,        16'h0001, 1'b0, 1'b0};
    tbl[2] = '{13'd99,       16'h0099, 1'b0, 1'b0};
    tbl[3] = '{13'h1FFF,     16'h0001, 1'b0, 1'b1};
    tbl[4] = '{13'(-1234),   16'h1234, 1'b0, 1'b1};
    tbl[5] = '{13'h1000,     16'h4096, 1'b0, 1'b1};
    tbl[6] = '{13'd4095,     16'h4095, 1'b0, 1'b0};
    tbl[7] = '{13'(-9),      16'h0009, 1'b0, 1'b1};
`else
    tbl[0] = '{13'd0,        16'h0000, 1'b0, 1'b0};
    tbl[1] = '{13'd1,        16'h0001, 1'b0, 1'b0};
    tbl[2] = '{13'd99,       16'h0099, 1'b0, 1'b0};
    tbl[3] = '{13'd8191,     16'h8191, 1'b0, 1'b0};
    tbl[4] = '{13'd1234,     16'h1234, 1'b0, 1'b0};
    tbl[5] = '{13'd4096,     16'h4096, 1'b0, 1'b0};
    tbl[6] = '{13'd4095,     16'h4095, 1'b0, 1'b0};
    tbl[7] = '{13'd5009,     16'h5009, 1'b0, 1'b0};
`endif

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_a = 13'd0; in_b = 13'd0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {31'h0, busy_a}, 32'd0);
    chk("reset.done", {31'h0, done_a}, 32'd0);
    chk("reset.bcd", {16'h0, bcd_a}, 32'd0);
    chk("reset.ovf", {31'h0, ovf_a}, 32'd0);
    chk("reset.sign", {31'h0, sign_a}, 32'd0);
    rst = 1'b0;

    conv_check("zero", 0, 13'd0);

    for (int i = 0; i < 8; i++) begin
      run(0, tbl[i].in, lat, ndone);
      chk($sformatf("tbl%0d.latency", i), 32'(lat), 32'd14);
      chk($sformatf("tbl%0d.bcd", i), {16'h0, bcd_a}, {16'h0, tbl[i].bcd});
      chk($sformatf("tbl%0d.ovf", i), {31'h0, ovf_a}, {31'h0, tbl[i].ovf});
      chk($sformatf("tbl%0d.sign", i), {31'h0, sign_a}, {31'h0, tbl[i].sgn});
    end

    // Back-to-back: start held through DONE
    @(negedge clk); in_a = 13'd8191; start_a = 1'b1;
    @(negedge clk); in_a = 13'd1234; lat = 1;
    while (!done_a && lat < 60) begin @(negedge clk); lat++; end
    ref_model(13'd8191, 4, eb, eo, es);
    chk("b2b.first_latency", 32'(lat), 32'd14);
    chk("b2b.first_bcd", {16'h0, bcd_a}, {16'h0, eb});
    @(negedge clk); start_a = 1'b0; lat2 = 1;
    chk("b2b.busy_after_done", {31'h0, busy_a}, 32'd1);
    while (!done_a && lat2 < 60) begin @(negedge clk); lat2++; end
    chk("b2b.second_gap", 32'(lat2), 32'd14);
    chk("b2b.second_bcd", {16'h0, bcd_a}, 32'h1234);

    // Start during SHIFT is ignored
    @(negedge clk); in_a = 13'd4321; start_a = 1'b1;
    ndone = 0; got = 16'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = (c == 5);
      if (c == 5) in_a = 13'd7777;
      if (done_a) begin ndone++; got = bcd_a; end
    end
    ref_model(13'd4321, 4, eb, eo, es);
    chk("ignore.done_count", 32'(ndone), 32'd1);
    chk("ignore.bcd", {16'h0, got}, {16'h0, eb});

    // Reset mid-conversion
    @(negedge clk); in_a = 13'd5555; start_a = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      rst = (c == 6);
      if (done_a) ndone++;
      if (c == 7) begin
        chk("midrst.busy", {31'h0, busy_a}, 32'd0);
        chk("midrst.bcd", {16'h0, bcd_a}, 32'd0);
        chk("midrst.sign", {31'h0, sign_a}, 32'd0);
      end
    end
    chk("midrst.no_done", 32'(ndone), 32'd0);
    chk("midrst.bcd_held", {16'h0, bcd_a}, 32'd0);
    conv_check("after_rst", 0, 13'd42);
    chk("after_rst.bcd42", {16'h0, bcd_a}, 32'h0042);

    // Three-digit instance overflow boundary
    conv_check("d3_1000", 1, 13'd1000);
    conv_check("d3_999", 1, 13'd999);
    chk("d3_999.bcd_const", {20'h0, bcd_b}, 32'h999);

    for (int i = 0; i < 30; i++) conv_check($sformatf("rand_a%0d", i), 0, 13'($urandom));
    for (int i = 0; i < 12; i++) conv_check($sformatf("rand_b%0d", i), 1, 13'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
